text_overlay: RTL and testbench

Character-cell text overlay stage downstream of the resource ROM block. Consumes the flat font bitmap vector that block produces, keeps an internal character buffer written by the game logic, and, for every pixel from the display timing chain, replaces the incoming colour with the foreground colour wherever a glyph bit is set. It sits between the image/background pixel source and the VGA output register.

---
 rtl/text_overlay_pkg.sv | 27 ++
 rtl/text_char_ram.sv | 35 +++
 rtl/text_overlay.sv | 235 +++++++++++++++++++++++
 tb/tb_text_overlay.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// Shared geometry defaults, clear-FSM state type and font addressing helper
// for the character-cell text overlay.
package text_overlay_pkg;

    localparam int COLS_DEF        = 80;
    localparam int ROWS_DEF        = 60;
    localparam int GLYPH_W_DEF     = 8;
    localparam int GLYPH_H_DEF     = 8;
    localparam int GLYPH_COUNT_DEF = 128;
    localparam int FONT_LENGTH_DEF = GLYPH_COUNT_DEF * GLYPH_W_DEF * GLYPH_H_DEF;

    localparam logic [11:0] FG_RGB_DEF = 12'hFFF;
    localparam logic [6:0]  SPACE_CHAR = 7'h20;
    localparam int          CHAR_W     = 7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Font vector is MSB-first, row-major, leftmost pixel first within a row.
    function automatic int font_bit_index(input int g, input int r, input int c,
                                          input int gw, input int gh, input int flen);
        return flen - 1 - ((g * gh + r) * gw + c);
    endfunction

endpackage

// File: rtl/text_char_ram.sv
// Character buffer: one write port, one registered read port. A read of the
// address being written in the same cycle returns the previous contents.
module text_char_ram #(
    parameter int DEPTH = 4800,
    parameter int AW    = 13,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Read mux ahead of the output register.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Storage and read register; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_overlay.sv
// Text overlay: character buffer with self-clearing FSM and a 3-stage pixel
// pipeline that paints glyph pixels in the foreground colour.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int          COLS        = COLS_DEF,
    parameter int          ROWS        = ROWS_DEF,
    parameter int          GLYPH_W     = GLYPH_W_DEF,
    parameter int          GLYPH_H     = GLYPH_H_DEF,
    parameter int          GLYPH_COUNT = GLYPH_COUNT_DEF,
    parameter logic [11:0] FG_RGB      = FG_RGB_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [GLYPH_COUNT*GLYPH_W*GLYPH_H-1:0]   font_data,
    input  logic                                     wr_en,
    input  logic [6:0]                               wr_col,
    input  logic [5:0]                               wr_row,
    input  logic [6:0]                               wr_char,
    input  logic                                     clear,
    output logic                                     busy,
    input  logic                                     pix_valid,
    input  logic [9:0]                               pix_x,
    input  logic [9:0]                               pix_y,
    input  logic [11:0]                              in_rgb,
    output logic                                     out_valid,
    output logic [11:0]                              out_rgb
);

    localparam int FONT_LEN = GLYPH_COUNT * GLYPH_W * GLYPH_H;
    localparam int CELLS    = ROWS * COLS;
    localparam int AW       = $clog2(CELLS);
    localparam int FIW      = $clog2(FONT_LEN);
    localparam int GXW      = $clog2(GLYPH_W);
    localparam int GYW      = $clog2(GLYPH_H);
    localparam int X_LIMIT  = COLS * GLYPH_W;
    localparam int Y_LIMIT  = ROWS * GLYPH_H;

    clr_state_e          state_q, state_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic                busy_q, busy_d;

    logic                wr_pend_q, wr_pend_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [CHAR_W-1:0]   wr_char_q, wr_char_d;

    logic                ram_we_s;
    logic [AW-1:0]       ram_waddr_s;
    logic [CHAR_W-1:0]   ram_wdata_s;
    logic [CHAR_W-1:0]   ram_rdata_s;

    logic                in_area_s;
    logic [AW-1:0]       pix_addr_s;
    logic                wr_in_range_s;
    logic [AW-1:0]       wr_addr_s;

    logic                s1_valid_q, s1_valid_d;
    logic [11:0]         s1_rgb_q, s1_rgb_d;
    logic [GXW-1:0]      s1_gx_q, s1_gx_d;
    logic [GYW-1:0]      s1_gy_q, s1_gy_d;
    logic                s1_in_area_q, s1_in_area_d;
    logic                s1_busy_q, s1_busy_d;
    logic [AW-1:0]       s1_addr_q, s1_addr_d;

    logic                s2_valid_q, s2_valid_d;
    logic [11:0]         s2_rgb_q, s2_rgb_d;
    logic [GXW-1:0]      s2_gx_q, s2_gx_d;
    logic [GYW-1:0]      s2_gy_q, s2_gy_d;
    logic                s2_hit_q, s2_hit_d;

    logic [FIW-1:0]      font_idx_s;
    logic                font_bit_s;
    logic                out_valid_q, out_valid_d;
    logic [11:0]         out_rgb_q, out_rgb_d;

    // Cell addressing for the incoming pixel and for the write request.
    always_comb begin
        in_area_s     = (32'(pix_x) < 32'(X_LIMIT)) && (32'(pix_y) < 32'(Y_LIMIT));
        pix_addr_s    = AW'(32'(pix_y >> GYW) * 32'(COLS) + 32'(pix_x >> GXW));
        wr_in_range_s = (32'(wr_col) < 32'(COLS)) && (32'(wr_row) < 32'(ROWS));
        wr_addr_s     = AW'(32'(wr_row) * 32'(COLS) + 32'(wr_col));
    end

    // Clear FSM next-state and clear address sequencing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == AW'(CELLS - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // RAM write port: clearing owns it, otherwise the registered user write.
    // User writes are delayed one cycle so a same-cycle pixel sees old data.
    always_comb begin
        busy_d      = (state_d == ST_CLEAR);
        wr_pend_d   = wr_en && !busy_q && wr_in_range_s;
        wr_addr_d   = wr_addr_s;
        wr_char_d   = wr_char;
        case (state_q)
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_addr_q;
                ram_wdata_s = SPACE_CHAR;
            end
            ST_IDLE: begin
                ram_we_s    = wr_pend_q;
                ram_waddr_s = wr_addr_q;
                ram_wdata_s = wr_char_q;
            end
            default: begin
                ram_we_s    = 1'b0;
                ram_waddr_s = '0;
                ram_wdata_s = SPACE_CHAR;
            end
        endcase
    end

    // Pixel pipeline: stage 1 capture, stage 2 alongside RAM read, stage 3 mux.
    always_comb begin
        s1_valid_d   = pix_valid;
        s1_rgb_d     = in_rgb;
        s1_gx_d      = pix_x[GXW-1:0];
        s1_gy_d      = pix_y[GYW-1:0];
        s1_in_area_d = in_area_s;
        s1_busy_d    = busy_q;
        if (in_area_s) begin
            s1_addr_d = pix_addr_s;
        end else begin
            s1_addr_d = '0;
        end

        s2_valid_d = s1_valid_q;
        s2_rgb_d   = s1_rgb_q;
        s2_gx_d    = s1_gx_q;
        s2_gy_d    = s1_gy_q;
        s2_hit_d   = s1_in_area_q && !s1_busy_q;

        font_idx_s  = FIW'(font_bit_index(int'(ram_rdata_s), int'(s2_gy_q), int'(s2_gx_q),
                                          GLYPH_W, GLYPH_H, FONT_LEN));
        font_bit_s  = font_data[font_idx_s];
        out_valid_d = s2_valid_q;
        if (s2_hit_q && font_bit_s) begin
            out_rgb_d = FG_RGB;
        end else begin
            out_rgb_d = s2_rgb_q;
        end
    end

    // All control and pipeline state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            busy_q       <= 1'b1;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_char_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_rgb_q     <= 12'h000;
            s1_gx_q      <= '0;
            s1_gy_q      <= '0;
            s1_in_area_q <= 1'b0;
            s1_busy_q    <= 1'b0;
            s1_addr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_rgb_q     <= 12'h000;
            s2_gx_q      <= '0;
            s2_gy_q      <= '0;
            s2_hit_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_rgb_q    <= 12'h000;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            busy_q       <= busy_d;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_char_q    <= wr_char_d;
            s1_valid_q   <= s1_valid_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_gx_q      <= s1_gx_d;
            s1_gy_q      <= s1_gy_d;
            s1_in_area_q <= s1_in_area_d;
            s1_busy_q    <= s1_busy_d;
            s1_addr_q    <= s1_addr_d;
            s2_valid_q   <= s2_valid_d;
            s2_rgb_q     <= s2_rgb_d;
            s2_gx_q      <= s2_gx_d;
            s2_gy_q      <= s2_gy_d;
            s2_hit_q     <= s2_hit_d;
            out_valid_q  <= out_valid_d;
            out_rgb_q    <= out_rgb_d;
        end
    end

    text_char_ram #(
        .DEPTH (CELLS),
        .AW    (AW),
        .DW    (CHAR_W)
    ) u_char_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (s1_addr_q),
        .rdata (ram_rdata_s)
    );

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: clear timing, glyph painting, area limits,
// write gating, read-before-write and asynchronous reset recovery.
module tb_text_overlay;

    localparam int FL = 128 * 8 * 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [FL-1:0]   font;
    logic            wr_en = 1'b0;
    logic [6:0]      wr_col = 7'd0;
    logic [5:0]      wr_row = 6'd0;
    logic [6:0]      wr_char = 7'd0;
    logic            clear = 1'b0;
    logic            busy;
    logic            pix_valid = 1'b0;
    logic [9:0]      pix_x = 10'd0;
    logic [9:0]      pix_y = 10'd0;
    logic [11:0]     in_rgb = 12'h000;
    logic            out_valid;
    logic [11:0]     out_rgb;

    int n_checks = 0;
    int n_pass   = 0;

    int          s_x   [16];
    int          s_y   [16];
    logic [11:0] s_rgb [16];
    logic        s_v   [16];
    logic        s_we  [16];
    logic [11:0] e_rgb [16];

    logic [7:0] a_rows [8] = '{8'h18, 8'h24, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h00};

    text_overlay dut (
        .clk       (clk),
        .rst       (rst),
        .font_data (font),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_char   (wr_char),
        .clear     (clear),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_rgb   (out_rgb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int col, input int row, input logic [6:0] ch);
        wr_en   = 1'b1;
        wr_col  = 7'(col);
        wr_row  = 6'(row);
        wr_char = ch;
        step();
        wr_en = 1'b0;
    endtask

    // Count cycles with busy high, starting at the current sample point.
    task automatic count_busy(input string tag, input int wr_at);
        int cnt = 0;
        while (busy && cnt < 6000) begin
            wr_en = (cnt == wr_at);
            cnt++;
            step();
        end
        wr_en = 1'b0;
        check_eq(tag, 32'(cnt), 32'd4800);
    endtask

    task automatic set_pix(input int i, input int x, input int y, input logic [11:0] rgb,
                           input logic v, input logic [11:0] exp);
        s_x[i] = x; s_y[i] = y; s_rgb[i] = rgb; s_v[i] = v; s_we[i] = 1'b0; e_rgb[i] = exp;
    endtask

    task automatic run_stream(input string tag, input int n);
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                check_eq($sformatf("%s%0d_valid", tag, i - 3), 32'(out_valid), 32'(s_v[i-3]));
                check_eq($sformatf("%s%0d_rgb", tag, i - 3), 32'(out_rgb), 32'(e_rgb[i-3]));
            end
            if (i < n) begin
                pix_x = 10'(s_x[i]); pix_y = 10'(s_y[i]);
                in_rgb = s_rgb[i]; pix_valid = s_v[i]; wr_en = s_we[i];
            end else begin
                pix_valid = 1'b0; wr_en = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        int nvalid;
        int nbad;

        // Every glyph solid except space (blank) and 'A'.
        font = '1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                font[FL - 1 - ((32'h20 * 8 + r) * 8 + c)] = 1'b0;
                font[FL - 1 - ((32'h41 * 8 + r) * 8 + c)] = a_rows[r][7-c];
            end
        end

        #2 rst = 1'b1;
        step(); step();
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_rgb", 32'(out_rgb), 32'h000);
        rst = 1'b0;
        count_busy("busy_after_reset", -1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Sweep every cell: a cleared cell is blank, anything else paints.
        nvalid = 0; nbad = 0;
        for (int i = 0; i < 4803; i++) begin
            if (out_valid) begin
                nvalid++;
                if (out_rgb !== 12'h0A5) nbad++;
            end
            if (i < 4800) begin
                pix_x = 10'((i % 80) * 8 + 3); pix_y = 10'((i / 80) * 8 + 5);
                in_rgb = 12'h0A5; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            step();
        end
        check_eq("sweep_valid_count", 32'(nvalid), 32'd4800);
        check_eq("sweep_bad_cells", 32'(nbad), 32'd0);

        // 'A' row 0 across cell (0,0).
        do_write(0, 0, 7'h41);
        do_write(0, 1, 7'h41);
        for (int i = 0; i < 8; i++) begin
            set_pix(i, i, 0, 12'h300 + 12'(i), 1'b1, (i == 3 || i == 4) ? 12'hFFF : 12'h300 + 12'(i));
        end
        run_stream("glyphA_x", 8);

        // Area boundaries, valid tracking and glyph row selection.
        set_pix(0, 640, 0,   12'h123, 1'b1, 12'h123);
        set_pix(1, 643, 0,   12'h123, 1'b1, 12'h123);
        set_pix(2, 3,   480, 12'h123, 1'b0, 12'h123);
        set_pix(3, 3,   8,   12'h456, 1'b1, 12'hFFF);
        set_pix(4, 2,   9,   12'h456, 1'b0, 12'hFFF);
        set_pix(5, 3,   9,   12'h456, 1'b1, 12'h456);
        set_pix(6, 639, 479, 12'h789, 1'b1, 12'h789);
        run_stream("area", 7);

        // Out-of-range column is dropped, then write to (5,3) races a pixel.
        do_write(85, 2, 7'h41);
        wr_col = 7'd5; wr_row = 6'd3; wr_char = 7'h41;
        set_pix(0, 43, 24, 12'h0F0, 1'b1, 12'h0F0);
        s_we[0] = 1'b1;
        set_pix(1, 43, 24, 12'h0F0, 1'b1, 12'hFFF);
        set_pix(2, 42, 24, 12'h0F0, 1'b1, 12'h0F0);
        run_stream("rbw", 3);

        // Clear pulse, restart at address 2000, write dropped while busy.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clear_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2000; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr_col = 7'd10; wr_row = 6'd10; wr_char = 7'h41;
        count_busy("busy_after_restart", 4000);
        set_pix(0, 83, 80, 12'h222, 1'b1, 12'h222);
        set_pix(1, 3,  0,  12'h222, 1'b1, 12'h222);
        set_pix(2, 43, 24, 12'h222, 1'b1, 12'h222);
        run_stream("after_clear", 3);

        // Asynchronous reset in the middle of a busy pipeline.
        do_write(0, 0, 7'h41);
        pix_x = 10'd3; pix_y = 10'd0; in_rgb = 12'h111; pix_valid = 1'b1;
        step(); step(); step(); step();
        check_eq("prerst_valid", 32'(out_valid), 32'd1);
        check_eq("prerst_rgb", 32'(out_rgb), 32'hFFF);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_rgb", 32'(out_rgb), 32'h000);
        check_eq("midrst_busy", 32'(busy), 32'd1);
        step();
        pix_valid = 1'b0;
        rst = 1'b0;
        count_busy("busy_after_midrst", -1);
        set_pix(0, 3, 0, 12'h333, 1'b1, 12'h333);
        set_pix(1, 4, 0, 12'h333, 1'b1, 12'h333);
        run_stream("post_rst", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
